// File: rtl/dot_matrix_main.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_main
// Brief    : 16x16 LED dot-matrix drive block with a column frame buffer,
//            a free-running column scan and blanking/column strobes.
// Revision : 1.0 - initial release
// ============================================================================

module dot_matrix_main #(
    parameter int SCAN_DIV     = 64,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] in_column,
    input  logic        IN_CLR,
    input  logic        LOAD,
    output logic [3:0]  column_seg,
    output logic [15:0] out_column,
    output logic        COLUMN_CLK,
    output logic        OUT_CLR
);

    localparam int              DIV_W   = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] C_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] C_HALF  = DIV_W'(SCAN_DIV / 2);
    localparam logic [DIV_W-1:0] C_BLANK = DIV_W'(BLANK_CYCLES);

    logic [15:0]      buffer [16];
    logic [3:0]       wr_ptr;
    logic             load_d;
    logic [DIV_W-1:0] div;
    logic             load_rise;

    assign load_rise = LOAD && !load_d;

    // Frame buffer and write pointer; IN_CLR swallows a coincident LOAD edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) buffer[i] <= '0;
            wr_ptr <= '0;
            load_d <= 1'b0;
        end else begin
            load_d <= LOAD;
            if (IN_CLR) begin
                for (int i = 0; i < 16; i++) buffer[i] <= '0;
                wr_ptr <= '0;
            end else if (load_rise) begin
                buffer[wr_ptr] <= in_column;
                wr_ptr         <= wr_ptr + 4'd1;
            end
        end
    end

    // Free-running scan: one column per SCAN_DIV cycles, 16 columns per frame.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div        <= '0;
            column_seg <= '0;
        end else if (div == C_LAST) begin
            div        <= '0;
            column_seg <= column_seg + 4'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign OUT_CLR    = (div < C_BLANK);
    assign COLUMN_CLK = (div >= C_HALF);
    assign out_column = OUT_CLR ? 16'h0000 : buffer[column_seg];

endmodule

`default_nettype wire

// File: tb/tb_dot_matrix_main.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_matrix_main
// Brief    : Directed self-checking bench for dot_matrix_main (SCAN_DIV=8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_dot_matrix_main;

    localparam int SD = 8;
    localparam int BL = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] in_column = '0;
    logic        IN_CLR = 1'b0;
    logic        LOAD = 1'b0;
    logic [3:0]  column_seg;
    logic [15:0] out_column;
    logic        COLUMN_CLK;
    logic        OUT_CLR;

    dot_matrix_main #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_column  (in_column),
        .IN_CLR     (IN_CLR),
        .LOAD       (LOAD),
        .column_seg (column_seg),
        .out_column (out_column),
        .COLUMN_CLK (COLUMN_CLK),
        .OUT_CLR    (OUT_CLR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          col;
        logic [31:0] val;
    } sb_t;

    sb_t         sbq[$];
    logic [15:0] mdl [16];
    int          mptr;
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mptr = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        clear_model();
        check("reset_outputs", {12'd0, column_seg, out_column, OUT_CLR, COLUMN_CLK},
              {12'd0, 4'd0, 16'h0000, 1'b1, 1'b0});
        RESET = 1'b0;
    endtask

    task automatic load_col(input logic [15:0] v);
        in_column = v;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        tick();
        mdl[mptr] = v;
        mptr = (mptr + 1) % 16;
    endtask

    // Called right after a reset edge; cycle k after reset is div=k%SD.
    task automatic timing_check(input string tag, input int n);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            sbq.push_back('{-1, {26'd0, 4'((k / SD) % 16), (k % SD) < BL, (k % SD) >= SD / 2}});
            e = sbq.pop_front();
            check(tag, {26'd0, column_seg, OUT_CLR, COLUMN_CLK}, e.val);
            tick();
        end
    endtask

    // Expect every column of the model to appear once in the scan.
    task automatic scan_frame(input string tag);
        sb_t e;
        int  budget;
        bit  blank_seen;
        blank_seen = 1'b0;
        budget = 3 * 16 * SD;
        for (int c = 0; c < 16; c++) sbq.push_back('{c, {16'd0, mdl[c]}});
        while (sbq.size() > 0 && budget > 0) begin
            if (!blank_seen && OUT_CLR && column_seg == 4'd0) begin
                blank_seen = 1'b1;
                check({tag, "_blank"}, {16'd0, out_column}, 32'd0);
            end
            if (!OUT_CLR && column_seg == 4'(sbq[0].col)) begin
                e = sbq.pop_front();
                check($sformatf("%s_col%0d", tag, e.col), {16'd0, out_column}, e.val);
            end else begin
                tick();
                budget--;
            end
        end
        if (sbq.size() > 0) begin
            check({tag, "_timeout"}, sbq.size(), 0);
            sbq.delete();
        end
    endtask

    initial begin
        bit prev_cc;
        bit found;
        int budget;

        // Reset, scan timing incl. 15->0 wrap, and an all-zero frame.
        do_reset();
        timing_check("scan_timing", 16 * SD + 4);
        scan_frame("reset_frame");

        // Single load held high: only entry 0 written.
        do_reset();
        in_column = 16'hFFFF;
        LOAD = 1'b1;
        tick();
        mdl[0] = 16'hFFFF;
        mptr = 1;
        in_column = 16'h1234;
        repeat (4) tick();
        LOAD = 1'b0;
        tick();
        scan_frame("single_load");

        // Pointer wrap: 17 writes, the last lands in entry 0 as 0x0000.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            logic [31:0] w;
            w = 32'h1 << k;
            load_col(w[15:0]);
        end
        scan_frame("ptr_wrap");

        // IN_CLR beats a coincident LOAD edge; held LOAD afterwards is no edge.
        in_column = 16'hABCD;
        LOAD = 1'b1;
        IN_CLR = 1'b1;
        tick();
        IN_CLR = 1'b0;
        clear_model();
        tick();
        LOAD = 1'b0;
        tick();
        scan_frame("in_clr");
        load_col(16'h5A5A);
        scan_frame("after_clr");

        // Reset mid-scan at column 9, div 5.
        found = 1'b0;
        prev_cc = COLUMN_CLK;
        budget = 3 * 16 * SD;
        while (!found && budget > 0) begin
            tick();
            budget--;
            if (column_seg == 4'd9 && COLUMN_CLK && !prev_cc) found = 1'b1;
            prev_cc = COLUMN_CLK;
        end
        check("mid_reset_found", {31'd0, found}, 32'd1);
        tick();
        RESET = 1'b1;
        tick();
        clear_model();
        check("mid_reset_outputs", {12'd0, column_seg, out_column, OUT_CLR, COLUMN_CLK},
              {12'd0, 4'd0, 16'h0000, 1'b1, 1'b0});
        RESET = 1'b0;
        timing_check("mid_reset_timing", 2 * SD);
        scan_frame("mid_reset_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
